// File: rtl/uio_link_pkg.sv
// Shared definitions for both ends of the inverted-bus uio link.
// The sender drives the bit-inverse of each byte; the receiver undoes it.
package uio_link_pkg;

  localparam int LINK_W = 8;

  typedef logic [LINK_W-1:0] link_word_t;

  function automatic link_word_t decode_word(input link_word_t w);
    return ~w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head word.
// rdata only moves on push-into-empty, on pop or on reset, so it is glitch-free while stalled.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rd_next = rd_ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_next;

      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // With one entry left, a simultaneous push becomes the new head directly.
      if (pop_ok) begin
        if (count > CW'(1))  rdata <= mem[rd_next];
        else if (push_ok)    rdata <= wdata;
      end else if (push_ok && empty) begin
        rdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/uio_rx_decoder.sv
// Receive side of the inverted uio link: synchronise pins, catch strobe rising edges,
// un-invert the byte and queue it toward uo_out with a sticky overflow flag.
module uio_rx_decoder
  import uio_link_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [LINK_W-1:0]      bus_d,
  input  logic                   bus_stb,
  output logic [LINK_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  link_word_t             d_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] stb_sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   stb_sync;
  logic                   stb_prev_q;
  logic                   armed_q;
  logic                   stb_rise;
  logic                   cap_vld_q;
  link_word_t             cap_word_q;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   push;
  logic                   drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) d_sync_q[i] <= '0;
      stb_sync_q <= '0;
    end else begin
      d_sync_q[0] <= bus_d;
      for (int i = 1; i < SYNC_STAGES; i++) d_sync_q[i] <= d_sync_q[i-1];
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], bus_stb};
    end
  end

  assign stb_sync = stb_sync_q[SYNC_STAGES-1];

  // After reset the synchroniser holds zeros, not the pin; only arm once the real
  // pin has been seen low, so a strobe held high through reset is not taken as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q     <= '0;
      armed_q    <= 1'b0;
      stb_prev_q <= 1'b0;
    end else begin
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      armed_q    <= armed_q | (fill_q[SYNC_STAGES-1] & ~stb_sync);
      stb_prev_q <= stb_sync;
    end
  end

  assign stb_rise = stb_sync & ~stb_prev_q & en & armed_q;

  // Single-cycle capture stage: holds the decoded word for the push/drop decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld_q  <= 1'b0;
      cap_word_q <= '0;
    end else begin
      cap_vld_q  <= stb_rise;
      if (stb_rise) cap_word_q <= decode_word(d_sync_q[SYNC_STAGES-1]);
    end
  end

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign push      = cap_vld_q & (~full | pop);
  assign drop      = cap_vld_q & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  sync_fifo #(
    .W     (LINK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (cap_word_q),
    .rdata (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule
